// File: rtl/can_tx_mailbox_scheduler_if.sv
// Host load port, mailbox status and transmitter handshake of the CAN TX mailbox scheduler.
// Handshake: a frame is offered while tx_req=1; a one-cycle tx_ack takes it and tx_req drops the next cycle.
interface can_tx_mailbox_scheduler_if #(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = $clog2(NUM_MB)
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [10:0]       wr_id_std;
  logic [17:0]       wr_id_ext;
  logic              wr_ide;
  logic              wr_rtr;
  logic [3:0]        wr_dlc;
  logic [63:0]       wr_data;
  logic              wr_reject;
  logic [NUM_MB-1:0] mb_abort;
  logic [NUM_MB-1:0] mb_pending;
  logic [NUM_MB-1:0] mb_tx_done;
  logic [NUM_MB-1:0] mb_tx_fail;
  logic              tx_req;
  logic              tx_ack;
  logic              tx_done;
  logic              tx_arb_lost;
  logic              tx_error;
  logic [10:0]       tx_id_std;
  logic [17:0]       tx_id_ext;
  logic              tx_ide;
  logic              tx_rtr;
  logic [3:0]        tx_dlc;
  logic [63:0]       tx_data;
  logic [IDX_W-1:0]  tx_mb_idx;

  modport master (
    output wr_en, wr_idx, wr_id_std, wr_id_ext, wr_ide, wr_rtr, wr_dlc, wr_data,
    output mb_abort, tx_ack, tx_done, tx_arb_lost, tx_error,
    input  wr_reject, mb_pending, mb_tx_done, mb_tx_fail, tx_req,
    input  tx_id_std, tx_id_ext, tx_ide, tx_rtr, tx_dlc, tx_data, tx_mb_idx
  );

  modport slave (
    input  wr_en, wr_idx, wr_id_std, wr_id_ext, wr_ide, wr_rtr, wr_dlc, wr_data,
    input  mb_abort, tx_ack, tx_done, tx_arb_lost, tx_error,
    output wr_reject, mb_pending, mb_tx_done, mb_tx_fail, tx_req,
    output tx_id_std, tx_id_ext, tx_ide, tx_rtr, tx_dlc, tx_data, tx_mb_idx
  );
endinterface

// File: rtl/can_tx_mailbox_scheduler.sv
// CAN TX mailbox scheduler: picks the highest-priority pending mailbox and hands it to the transmitter.
// Optional CAN_TX_RETRY_LIMIT_EN: drop a mailbox after RETRY_LIMIT transmit errors.
module can_tx_mailbox_scheduler #(
  parameter int NUM_MB      = 4,
  parameter int RETRY_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  can_tx_mailbox_scheduler_if.slave bus,
  output logic [1:0]                dbg_state
);
  localparam int IDX_W = $clog2(NUM_MB);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_BUSY   = 2'd3
  } state_t;

  if (NUM_MB < 2 || NUM_MB > 8 || RETRY_LIMIT < 1 || RETRY_LIMIT > 31) begin : g_param_check
    $error("can_tx_mailbox_scheduler: NUM_MB must be 2..8 and RETRY_LIMIT 1..31");
  end

  state_t            state_q, state_d;
  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [NUM_MB-1:0] done_q, done_d;
  logic [NUM_MB-1:0] fail_q, fail_d;
  logic              reject_q, reject_d;

  logic [10:0]       id_std_q [NUM_MB];
  logic [10:0]       id_std_d [NUM_MB];
  logic [17:0]       id_ext_q [NUM_MB];
  logic [17:0]       id_ext_d [NUM_MB];
  logic [3:0]        dlc_q    [NUM_MB];
  logic [3:0]        dlc_d    [NUM_MB];
  logic [63:0]       data_q   [NUM_MB];
  logic [63:0]       data_d   [NUM_MB];
  logic [NUM_MB-1:0] ide_q, ide_d;
  logic [NUM_MB-1:0] rtr_q, rtr_d;

  logic [10:0]       tx_id_std_q, tx_id_std_d;
  logic [17:0]       tx_id_ext_q, tx_id_ext_d;
  logic              tx_ide_q, tx_ide_d;
  logic              tx_rtr_q, tx_rtr_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;

`ifdef CAN_TX_RETRY_LIMIT_EN
  logic [4:0]        retry_q [NUM_MB];
  logic [4:0]        retry_d [NUM_MB];
`endif

  logic [31:0]       key [NUM_MB];
  logic [31:0]       best_key;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic              owned;
  logic              wr_in_range;

  // Arbitration field as it appears on the bus; SRR and IDE are recessive (1) for extended frames.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) begin
      if (ide_q[i]) key[i] = {id_std_q[i], 1'b1, 1'b1, id_ext_q[i], rtr_q[i]};
      else          key[i] = {id_std_q[i], rtr_q[i], 1'b0, 18'h0, 1'b0};
    end
  end

  // Strict less-than while scanning upward, so equal keys resolve to the lowest index.
  always_comb begin
    best_key = '1;
    win_idx  = '0;
    win_vld  = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && (!win_vld || key[i] < best_key)) begin
        best_key = key[i];
        win_idx  = IDX_W'(i);
        win_vld  = 1'b1;
      end
    end
  end

  assign owned       = (state_q == S_REQ) || (state_q == S_BUSY);
  assign wr_in_range = int'(bus.wr_idx) < NUM_MB;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = '0;
    fail_d      = '0;
    reject_d    = 1'b0;
    id_std_d    = id_std_q;
    id_ext_d    = id_ext_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    ide_d       = ide_q;
    rtr_d       = rtr_q;
    tx_id_std_d = tx_id_std_q;
    tx_id_ext_d = tx_id_ext_q;
    tx_ide_d    = tx_ide_q;
    tx_rtr_d    = tx_rtr_q;
    tx_dlc_d    = tx_dlc_q;
    tx_data_d   = tx_data_q;
    tx_idx_d    = tx_idx_q;
`ifdef CAN_TX_RETRY_LIMIT_EN
    retry_d     = retry_q;
`endif

    // Aborts of mailboxes not currently owned by the transmitter take effect immediately.
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && bus.mb_abort[i] && !(owned && tx_idx_q == IDX_W'(i))) begin
        pending_d[i] = 1'b0;
        fail_d[i]    = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (win_vld && !bus.mb_abort[win_idx]) begin
          tx_id_std_d = id_std_q[win_idx];
          tx_id_ext_d = id_ext_q[win_idx];
          tx_ide_d    = ide_q[win_idx];
          tx_rtr_d    = rtr_q[win_idx];
          tx_dlc_d    = dlc_q[win_idx];
          tx_data_d   = data_q[win_idx];
          tx_idx_d    = win_idx;
          state_d     = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.tx_ack) begin
          state_d = S_BUSY;
        end else if (bus.mb_abort[tx_idx_q]) begin
          pending_d[tx_idx_q] = 1'b0;
          fail_d[tx_idx_q]    = 1'b1;
          state_d             = S_IDLE;
        end
      end
      S_BUSY: begin
        // An abort raised during the attempt only decides how a failed attempt is reported.
        if (bus.tx_done) begin
          pending_d[tx_idx_q] = 1'b0;
          done_d[tx_idx_q]    = 1'b1;
          state_d             = S_IDLE;
        end else if (bus.tx_error) begin
          if (bus.mb_abort[tx_idx_q]) begin
            pending_d[tx_idx_q] = 1'b0;
            fail_d[tx_idx_q]    = 1'b1;
          end
`ifdef CAN_TX_RETRY_LIMIT_EN
          else if (retry_q[tx_idx_q] == 5'(RETRY_LIMIT - 1)) begin
            pending_d[tx_idx_q] = 1'b0;
            fail_d[tx_idx_q]    = 1'b1;
          end else begin
            retry_d[tx_idx_q] = retry_q[tx_idx_q] + 5'd1;
          end
`endif
          state_d = S_IDLE;
        end else if (bus.tx_arb_lost) begin
          if (bus.mb_abort[tx_idx_q]) begin
            pending_d[tx_idx_q] = 1'b0;
            fail_d[tx_idx_q]    = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Writes only ever land on idle mailboxes, so they never collide with the clears above.
    if (bus.wr_en && wr_in_range) begin
      if (pending_q[bus.wr_idx]) begin
        reject_d = 1'b1;
      end else begin
        pending_d[bus.wr_idx] = 1'b1;
        id_std_d[bus.wr_idx]  = bus.wr_id_std;
        id_ext_d[bus.wr_idx]  = bus.wr_id_ext;
        ide_d[bus.wr_idx]     = bus.wr_ide;
        rtr_d[bus.wr_idx]     = bus.wr_rtr;
        dlc_d[bus.wr_idx]     = bus.wr_dlc;
        data_d[bus.wr_idx]    = bus.wr_data;
      end
    end

`ifdef CAN_TX_RETRY_LIMIT_EN
    // Any pending transition (success, abort, drop or a fresh load) restarts the error count.
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_d[i] != pending_q[i]) retry_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      done_q      <= '0;
      fail_q      <= '0;
      reject_q    <= 1'b0;
      ide_q       <= '0;
      rtr_q       <= '0;
      tx_id_std_q <= '0;
      tx_id_ext_q <= '0;
      tx_ide_q    <= 1'b0;
      tx_rtr_q    <= 1'b0;
      tx_dlc_q    <= '0;
      tx_data_q   <= '0;
      tx_idx_q    <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        id_std_q[i] <= '0;
        id_ext_q[i] <= '0;
        dlc_q[i]    <= '0;
        data_q[i]   <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
        retry_q[i]  <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      reject_q    <= reject_d;
      ide_q       <= ide_d;
      rtr_q       <= rtr_d;
      tx_id_std_q <= tx_id_std_d;
      tx_id_ext_q <= tx_id_ext_d;
      tx_ide_q    <= tx_ide_d;
      tx_rtr_q    <= tx_rtr_d;
      tx_dlc_q    <= tx_dlc_d;
      tx_data_q   <= tx_data_d;
      tx_idx_q    <= tx_idx_d;
      id_std_q    <= id_std_d;
      id_ext_q    <= id_ext_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
`ifdef CAN_TX_RETRY_LIMIT_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.wr_reject  = reject_q;
  assign bus.mb_pending = pending_q;
  assign bus.mb_tx_done = done_q;
  assign bus.mb_tx_fail = fail_q;
  assign bus.tx_req     = (state_q == S_REQ);
  assign bus.tx_id_std  = tx_id_std_q;
  assign bus.tx_id_ext  = tx_id_ext_q;
  assign bus.tx_ide     = tx_ide_q;
  assign bus.tx_rtr     = tx_rtr_q;
  assign bus.tx_dlc     = tx_dlc_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_mb_idx  = tx_idx_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_can_tx_mailbox_scheduler.sv
// Directed bench for can_tx_mailbox_scheduler; the retry section follows CAN_TX_RETRY_LIMIT_EN.
module tb_can_tx_mailbox_scheduler;
  localparam int NUM_MB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  can_tx_mailbox_scheduler_if #(.NUM_MB(NUM_MB)) bus ();

  can_tx_mailbox_scheduler #(.NUM_MB(NUM_MB), .RETRY_LIMIT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic wr_mb(input int idx, input logic [10:0] id_std, input logic [17:0] id_ext,
                       input logic ide, input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    bus.wr_en     = 1'b1;
    bus.wr_idx    = idx[1:0];
    bus.wr_id_std = id_std;
    bus.wr_id_ext = id_ext;
    bus.wr_ide    = ide;
    bus.wr_rtr    = rtr;
    bus.wr_dlc    = dlc;
    bus.wr_data   = data;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.tx_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " tx_req"}, bus.tx_req, 1);
  endtask

  task automatic serve_done(input string tag, input int idx, input logic [10:0] id);
    wait_req(tag);
    chk({tag, " idx"}, bus.tx_mb_idx, idx);
    chk({tag, " id"}, bus.tx_id_std, id);
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk({tag, " req drop"}, bus.tx_req, 0);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk({tag, " done pulse"}, bus.mb_tx_done, 1 << idx);
    chk({tag, " pend clr"}, bus.mb_pending[idx], 0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_id_std = '0; bus.wr_id_ext = '0;
    bus.wr_ide = 1'b0; bus.wr_rtr = 1'b0; bus.wr_dlc = '0; bus.wr_data = '0;
    bus.mb_abort = '0; bus.tx_ack = 1'b0; bus.tx_done = 1'b0;
    bus.tx_arb_lost = 1'b0; bus.tx_error = 1'b0;

    // reset
    repeat (3) step();
    chk("rst pending", bus.mb_pending, 0);
    chk("rst tx_req", bus.tx_req, 0);
    chk("rst state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    // 1: single frame, latency and snapshot
    wr_mb(0, 11'h7FF, 18'h0, 1'b0, 1'b0, 4'd2, 64'hCDAB);
    chk("t1 pending", bus.mb_pending, 4'b0001);
    chk("t1 req k", bus.tx_req, 0);
    step();
    chk("t1 req k+1", bus.tx_req, 0);
    step();
    chk("t1 req k+2", bus.tx_req, 1);
    chk("t1 dlc", bus.tx_dlc, 2);
    chk("t1 data", bus.tx_data, 64'hCDAB);
    serve_done("t1", 0, 11'h7FF);
    step();
    chk("t1 done one-shot", bus.mb_tx_done, 0);

    // tx_done outside BUSY is ignored
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("idle done ignored", bus.mb_tx_done, 0);
    chk("idle state", dbg_state, 0);

    // 2: priority order mb1, mb2 (rtr), mb0
    wr_mb(1, 11'h100, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wr_mb(2, 11'h100, 18'h0, 1'b0, 1'b1, 4'd0, 64'h0);
    wr_mb(0, 11'h123, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    serve_done("t2 first", 1, 11'h100);
    wait_req("t2 second");
    chk("t2 second rtr", bus.tx_rtr, 1);
    serve_done("t2 second", 2, 11'h100);
    serve_done("t2 third", 0, 11'h123);

    // 3: standard beats extended with same base id; identical keys resolve to lower index
    wr_mb(1, 11'h100, 18'h0, 1'b1, 1'b0, 4'd0, 64'h0);
    wr_mb(0, 11'h100, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    serve_done("t3 std", 0, 11'h100);
    wait_req("t3 ext");
    chk("t3 ext ide", bus.tx_ide, 1);
    serve_done("t3 ext", 1, 11'h100);
    wr_mb(3, 11'h055, 18'h0, 1'b0, 1'b0, 4'd1, 64'h11);
    wr_mb(2, 11'h055, 18'h0, 1'b0, 1'b0, 4'd1, 64'h11);
    serve_done("t3 tie lo", 2, 11'h055);
    serve_done("t3 tie hi", 3, 11'h055);

    // 4: arbitration loss re-queues; higher-priority newcomer wins; write to pending rejected
    wr_mb(0, 11'h400, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_req("t4 mb0");
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack      = 1'b0;
    bus.tx_arb_lost = 1'b1;
    bus.wr_en = 1'b1; bus.wr_idx = 2'd3; bus.wr_id_std = 11'h010; bus.wr_ide = 1'b0; bus.wr_rtr = 1'b0;
    step();
    bus.tx_arb_lost = 1'b0;
    bus.wr_en       = 1'b0;
    chk("t4 both pending", bus.mb_pending, 4'b1001);
    chk("t4 no fail", bus.mb_tx_fail, 0);
    wait_req("t4 mb3");
    chk("t4 sel mb3", bus.tx_mb_idx, 3);
    wr_mb(3, 11'h001, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    chk("t4 reject", bus.wr_reject, 1);
    chk("t4 snapshot", bus.tx_id_std, 11'h010);
    serve_done("t4 mb3", 3, 11'h010);
    serve_done("t4 mb0", 0, 11'h400);

    // 5: abort handling
    wr_mb(0, 11'h010, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wr_mb(2, 11'h300, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_req("t5 mb0");
    chk("t5 sel mb0", bus.tx_mb_idx, 0);
    bus.mb_abort = 4'b0100;
    step();
    bus.mb_abort = 4'b0000;
    chk("t5 abort mb2 fail", bus.mb_tx_fail, 4'b0100);
    chk("t5 abort mb2 pend", bus.mb_pending, 4'b0001);
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack   = 1'b0;
    bus.mb_abort = 4'b0001;
    step();
    chk("t5 busy abort held", bus.mb_pending, 4'b0001);
    chk("t5 busy abort nofail", bus.mb_tx_fail, 0);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done  = 1'b0;
    bus.mb_abort = 4'b0000;
    chk("t5 abort+done done", bus.mb_tx_done, 4'b0001);
    chk("t5 abort+done fail", bus.mb_tx_fail, 0);
    chk("t5 abort+done pend", bus.mb_pending, 0);
    wr_mb(1, 11'h111, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_req("t5 mb1");
    bus.mb_abort = 4'b0010;
    step();
    bus.mb_abort = 4'b0000;
    chk("t5 req abort fail", bus.mb_tx_fail, 4'b0010);
    chk("t5 req abort pend", bus.mb_pending, 0);
    chk("t5 req abort req", bus.tx_req, 0);
    wr_mb(3, 11'h333, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_req("t5 mb3");
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack      = 1'b0;
    bus.mb_abort    = 4'b1000;
    bus.tx_arb_lost = 1'b1;
    step();
    bus.mb_abort    = 4'b0000;
    bus.tx_arb_lost = 1'b0;
    chk("t5 busy arb fail", bus.mb_tx_fail, 4'b1000);
    chk("t5 busy arb pend", bus.mb_pending, 0);

    // 6: repeated transmit errors
    wr_mb(1, 11'h222, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    for (int a = 0; a < 3; a++) begin
      wait_req("t6 attempt");
      bus.tx_ack = 1'b1;
      step();
      bus.tx_ack   = 1'b0;
      bus.tx_error = 1'b1;
      step();
      bus.tx_error = 1'b0;
      if (a < 2) begin
        chk("t6 kept", bus.mb_pending, 4'b0010);
        chk("t6 no fail", bus.mb_tx_fail, 0);
      end
    end
`ifdef CAN_TX_RETRY_LIMIT_EN
    chk("t6 dropped fail", bus.mb_tx_fail, 4'b0010);
    chk("t6 dropped pend", bus.mb_pending, 0);
`else
    chk("t6 requeued pend", bus.mb_pending, 4'b0010);
    chk("t6 requeued nofail", bus.mb_tx_fail, 0);
    serve_done("t6 4th", 1, 11'h222);
`endif

    // reset while BUSY
    wr_mb(0, 11'h3AB, 18'h5, 1'b1, 1'b0, 4'd8, 64'hFFFF_0000_1234_5678);
    wait_req("rb req");
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk("rb busy", dbg_state, 3);
    rst_n = 1'b0;
    #2;
    chk("rb tx_req", bus.tx_req, 0);
    chk("rb pending", bus.mb_pending, 0);
    chk("rb id", bus.tx_id_std, 0);
    chk("rb data", bus.tx_data, 0);
    chk("rb state", dbg_state, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
